zjh_modn_counter: RTL and testbench



---
 rtl/zjh_cnt_pkg.sv | 26 ++
 rtl/zjh_cnt_tc.sv | 43 ++++
 rtl/zjh_modn_counter.sv | 66 ++++++
 tb/tb_zjh_modn_counter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/zjh_cnt_pkg.sv
// Shared types and helpers for the zjh mod-N counter family.
// Also used by the optional up/down build (macro ZJH_CNT_UPDOWN_EN).
package zjh_cnt_pkg;

    typedef enum logic {
        CNT_UP   = 1'b0,
        CNT_DOWN = 1'b1
    } cnt_mode_e;

    localparam int TERM_BITS = 17;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Terminal value MODULUS-1, wide enough for WIDTH=16 with MODULUS=2**16.
    function automatic logic [TERM_BITS-1:0] term_value(input int modulus);
        return TERM_BITS'(modulus - 1);
    endfunction

endpackage

// File: rtl/zjh_cnt_tc.sv
// Combinational next-value and raw terminal-count decode for the mod-N counter.
// The down direction is exercised only when ZJH_CNT_UPDOWN_EN is defined at the top.
module zjh_cnt_tc
    import zjh_cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 14
) (
    input  logic [WIDTH-1:0] q,
    input  cnt_mode_e        mode,
    output logic [WIDTH-1:0] cnt_next,
    output logic             tc_raw
);

    localparam logic [TERM_BITS-1:0] TERM_FULL = term_value(MODULUS);
    localparam logic [WIDTH:0]       TERM      = TERM_FULL[WIDTH:0];

    logic [WIDTH:0] q_ext;

    // Compare one bit wider so MODULUS == 2**WIDTH does not overflow.
    assign q_ext = {1'b0, q};

    always_comb begin
        cnt_next = q;
        tc_raw   = 1'b0;
        if (mode == CNT_UP) begin
            tc_raw = (q_ext == TERM);
            if (q_ext >= TERM) begin
                cnt_next = '0;
            end else begin
                cnt_next = q + 1'b1;
            end
        end else begin
            tc_raw = (q == '0);
            if ((q == '0) || (q_ext > TERM)) begin
                cnt_next = TERM[WIDTH-1:0];
            end else begin
                cnt_next = q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/zjh_modn_counter.sv
// Parametrised 74HC161-style mod-N counter with load, CEP/CET and cascadable C.
// Define ZJH_CNT_UPDOWN_EN to add the UD direction input.
module zjh_modn_counter
    import zjh_cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 14
) (
    input  logic             Clk,
    input  logic             MR,
    input  logic             PE_n,
    input  logic             CEP,
    input  logic             CET,
`ifdef ZJH_CNT_UPDOWN_EN
    input  logic             UD,
`endif
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             C
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] cnt_next;
    logic             tc_raw;
    cnt_mode_e        mode;

`ifdef ZJH_CNT_UPDOWN_EN
    assign mode = UD ? CNT_UP : CNT_DOWN;
`else
    assign mode = CNT_UP;
`endif

    zjh_cnt_tc #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_tc (
        .q        (q_reg),
        .mode     (mode),
        .cnt_next (cnt_next),
        .tc_raw   (tc_raw)
    );

    // Load beats counting; anything else holds.
    always_comb begin
        q_next = q_reg;
        if (!PE_n) begin
            q_next = D;
        end else if (CEP && CET) begin
            q_next = cnt_next;
        end
    end

    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign Q = q_reg;
    // CEP deliberately left out so a held lower stage can still enable the next one.
    assign C = CET & tc_raw;

endmodule

// File: tb/tb_zjh_modn_counter.sv
// Directed bench for zjh_modn_counter: reset, free run, load/enable table, BCD cascade.
module tb_zjh_modn_counter;

    logic       clk;
    logic       mr;
    logic       pe_n;
    logic       cep;
    logic       cet;
    logic [3:0] d;
    logic [3:0] q;
    logic       c;
    logic [3:0] lo_q;
    logic [3:0] hi_q;
    logic       lo_c;
    logic       hi_c;
`ifdef ZJH_CNT_UPDOWN_EN
    logic       ud;
`endif

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    zjh_modn_counter #(.WIDTH(4), .MODULUS(14)) dut (
        .Clk  (clk),
        .MR   (mr),
        .PE_n (pe_n),
        .CEP  (cep),
        .CET  (cet),
`ifdef ZJH_CNT_UPDOWN_EN
        .UD   (ud),
`endif
        .D    (d),
        .Q    (q),
        .C    (c)
    );

    zjh_modn_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
        .Clk  (clk),
        .MR   (mr),
        .PE_n (1'b1),
        .CEP  (1'b1),
        .CET  (1'b1),
`ifdef ZJH_CNT_UPDOWN_EN
        .UD   (1'b1),
`endif
        .D    (4'd0),
        .Q    (lo_q),
        .C    (lo_c)
    );

    zjh_modn_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
        .Clk  (clk),
        .MR   (mr),
        .PE_n (1'b1),
        .CEP  (1'b1),
        .CET  (lo_c),
`ifdef ZJH_CNT_UPDOWN_EN
        .UD   (1'b1),
`endif
        .D    (4'd0),
        .Q    (hi_q),
        .C    (hi_c)
    );

    typedef struct {
        logic       pe_n;
        logic       cep;
        logic       cet;
        logic [3:0] d;
        logic [3:0] exp_q;
        logic       exp_c;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s value=%0d", name, act);
        end
    endtask

    task automatic drive(input logic p, input logic ep, input logic et, input logic [3:0] dv);
        pe_n = p;
        cep  = ep;
        cet  = et;
        d    = dv;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        mr = 1'b0;
        #2;
        @(negedge clk);
        mr = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp;
        int sub;
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 4'd5,  4'd5,  1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 4'd0,  4'd6,  1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'd15, 4'd15, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 4'd0,  4'd0,  1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'd12, 4'd12, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 4'd0,  4'd13, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'd0,  4'd13, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'd0,  4'd13, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'd0,  4'd13, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 4'd0,  4'd0,  1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'd13, 4'd13, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 4'd14, 4'd14, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 4'd0,  4'd0,  1'b0};

        mr = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 4'd0);
`ifdef ZJH_CNT_UPDOWN_EN
        ud = 1'b1;
`endif
        #12;
        check("reset_q", int'(q), 0);
        check("reset_c", int'(c), 0);

        // Asynchronous reset mid-count at Q=9.
        @(negedge clk);
        mr = 1'b1;
        repeat (9) edge_step();
        check("pre_reset_q", int'(q), 9);
        #1;
        mr = 1'b0;
        #1;
        check("async_reset_q", int'(q), 0);
        check("async_reset_c", int'(c), 0);
        @(negedge clk);
        mr = 1'b1;
        edge_step();
        check("post_reset_q1", int'(q), 1);
        edge_step();
        check("post_reset_q2", int'(q), 2);

        // Free run over two full periods.
        do_reset();
        exp = 0;
        for (int i = 0; i < 30; i++) begin
            edge_step();
            exp = (exp == 13) ? 0 : exp + 1;
            check($sformatf("run_q[%0d]", i), int'(q), exp);
            check($sformatf("run_c[%0d]", i), int'(c), (exp == 13) ? 1 : 0);
        end

        // Load / enable table from a cleared counter.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].pe_n, vecs[i].cep, vecs[i].cet, vecs[i].d);
            edge_step();
            check($sformatf("vec_q[%0d]", i), int'(q), int'(vecs[i].exp_q));
            check($sformatf("vec_c[%0d]", i), int'(c), int'(vecs[i].exp_c));
        end

        // BCD cascade 00..99 and rollover.
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        do_reset();
        check("bcd_reset", int'(hi_q) * 10 + int'(lo_q), 0);
        for (int k = 1; k <= 101; k++) begin
            edge_step();
            sub = k % 100;
            check($sformatf("bcd[%0d]", k), int'(hi_q) * 10 + int'(lo_q), sub);
            check($sformatf("bcd_c[%0d]", k), int'(hi_c), (sub == 99) ? 1 : 0);
        end

`ifdef ZJH_CNT_UPDOWN_EN
        drive(1'b0, 1'b1, 1'b1, 4'd2);
        ud = 1'b0;
        edge_step();
        check("ud_load", int'(q), 2);
        drive(1'b1, 1'b1, 1'b1, 4'd0);
        edge_step();
        check("ud_down1", int'(q), 1);
        edge_step();
        check("ud_down0", int'(q), 0);
        check("ud_c_at0", int'(c), 1);
        edge_step();
        check("ud_wrap13", int'(q), 13);
        check("ud_c_at13", int'(c), 0);
        edge_step();
        check("ud_down12", int'(q), 12);
        @(negedge clk);
        ud = 1'b1;
        #1;
        edge_step();
        check("ud_up13", int'(q), 13);
        check("ud_up_c", int'(c), 1);
        edge_step();
        check("ud_up0", int'(q), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
